// File: rtl/video_pattern_gen.sv
// Timing/pattern generator: frames of VBLANK, then per line HBLANK + ACTIVE, with
// optionally sparse pixel-valid strobes and four selectable test patterns.
module video_pattern_gen #(
    parameter int WIDTH         = 8,
    parameter int SPARSE_OUTPUT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [15:0]      pix_count,
    input  logic [15:0]      line_count,
    input  logic [15:0]      hblank_count,
    input  logic [15:0]      vblank_count,
    input  logic [1:0]       pattern_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dv_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

    localparam logic [15:0] SUB_LAST = 16'(SPARSE_OUTPUT - 1);

    state_t           state_reg, state_next;
    logic [15:0]      blank_cnt_reg, blank_cnt_next;
    logic [15:0]      sub_cnt_reg, sub_cnt_next;
    logic [15:0]      x_reg, x_next;
    logic [15:0]      y_reg, y_next;
    logic [15:0]      pix_lat_reg, pix_lat_next;
    logic [15:0]      line_lat_reg, line_lat_next;
    logic [15:0]      hbl_last_reg, hbl_last_next;
    logic [15:0]      vbl_last_reg, vbl_last_next;
    logic [1:0]       pat_lat_reg, pat_lat_next;

    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dv_reg, dv_next;
    logic             hs_reg, hs_next;
    logic             vs_reg, vs_next;
    logic [7:0]       frame_cnt_reg, frame_cnt_next;

    logic             start_ok;
    logic             latch_frame;
    logic [WIDTH-1:0] pix_val;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            blank_cnt_reg <= '0;
            sub_cnt_reg   <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            pix_lat_reg   <= '0;
            line_lat_reg  <= '0;
            hbl_last_reg  <= '0;
            vbl_last_reg  <= '0;
            pat_lat_reg   <= '0;
            dout_reg      <= '0;
            dv_reg        <= 1'b0;
            hs_reg        <= 1'b0;
            vs_reg        <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            blank_cnt_reg <= blank_cnt_next;
            sub_cnt_reg   <= sub_cnt_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            pix_lat_reg   <= pix_lat_next;
            line_lat_reg  <= line_lat_next;
            hbl_last_reg  <= hbl_last_next;
            vbl_last_reg  <= vbl_last_next;
            pat_lat_reg   <= pat_lat_next;
            dout_reg      <= dout_next;
            dv_reg        <= dv_next;
            hs_reg        <= hs_next;
            vs_reg        <= vs_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Next-state logic; blank lengths are stored as (count-1) with 0 treated as 1
    always_comb begin
        state_next     = state_reg;
        blank_cnt_next = blank_cnt_reg;
        sub_cnt_next   = sub_cnt_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        pix_lat_next   = pix_lat_reg;
        line_lat_next  = line_lat_reg;
        hbl_last_next  = hbl_last_reg;
        vbl_last_next  = vbl_last_reg;
        pat_lat_next   = pat_lat_reg;
        latch_frame    = 1'b0;
        start_ok       = enable && (pix_count != 16'd0) && (line_count != 16'd0);

        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next  = VBLANK;
                    latch_frame = 1'b1;
                end
            end
            VBLANK: begin
                if (blank_cnt_reg == vbl_last_reg) begin
                    state_next     = HBLANK;
                    blank_cnt_next = '0;
                end else begin
                    blank_cnt_next = blank_cnt_reg + 16'd1;
                end
            end
            HBLANK: begin
                if (blank_cnt_reg == hbl_last_reg) begin
                    state_next     = ACTIVE;
                    blank_cnt_next = '0;
                    sub_cnt_next   = '0;
                    x_next         = '0;
                end else begin
                    blank_cnt_next = blank_cnt_reg + 16'd1;
                end
            end
            ACTIVE: begin
                if (sub_cnt_reg == SUB_LAST) begin
                    sub_cnt_next = '0;
                    if (x_reg == pix_lat_reg - 16'd1) begin
                        x_next         = '0;
                        blank_cnt_next = '0;
                        if (y_reg == line_lat_reg - 16'd1) begin
                            y_next = '0;
                            if (start_ok) begin
                                state_next  = VBLANK;
                                latch_frame = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            y_next     = y_reg + 16'd1;
                            state_next = HBLANK;
                        end
                    end else begin
                        x_next = x_reg + 16'd1;
                    end
                end else begin
                    sub_cnt_next = sub_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (latch_frame) begin
            pix_lat_next   = pix_count;
            line_lat_next  = line_count;
            hbl_last_next  = (hblank_count == 16'd0) ? 16'd0 : hblank_count - 16'd1;
            vbl_last_next  = (vblank_count == 16'd0) ? 16'd0 : vblank_count - 16'd1;
            pat_lat_next   = pattern_sel;
            blank_cnt_next = '0;
            sub_cnt_next   = '0;
            x_next         = '0;
            y_next         = '0;
        end
    end

    // Output decode from the current state; registered, so it lags the FSM by one clock
    always_comb begin
        case (pat_lat_reg)
            2'd0:    pix_val = WIDTH'(x_reg);
            2'd1:    pix_val = WIDTH'(y_reg);
            2'd2:    pix_val = {WIDTH{x_reg[3] ^ y_reg[3]}};
            default: pix_val = WIDTH'(x_reg) + WIDTH'(y_reg) + WIDTH'(frame_cnt_reg);
        endcase
        dv_next        = (state_reg == ACTIVE) && (sub_cnt_reg == 16'd0);
        hs_next        = (state_reg == ACTIVE);
        vs_next        = (state_reg == HBLANK) || (state_reg == ACTIVE);
        dout_next      = dv_next ? pix_val : '0;
        frame_cnt_next = (vs_reg && !vs_next) ? frame_cnt_reg + 8'd1 : frame_cnt_reg;
    end

    assign dout      = dout_reg;
    assign dv_out    = dv_reg;
    assign hs_out    = hs_reg;
    assign vs_out    = vs_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: continuous (S=1) and sparse (S=2) instances checked
// every clock against a frame-position arithmetic model.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pix_count, line_count, hblank_count, vblank_count;
    logic [1:0]  pattern_sel;

    logic [7:0]  dout_w      [2];
    logic        dv_w        [2];
    logic        hs_w        [2];
    logic        vs_w        [2];
    logic [7:0]  frame_cnt_w [2];

    always #5 clk = ~clk;

    // Instance gi runs with SPARSE_OUTPUT = gi+1
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            video_pattern_gen #(.WIDTH(8), .SPARSE_OUTPUT(gi + 1)) dut (
                .clk          (clk),
                .rst          (rst),
                .enable       (enable),
                .pix_count    (pix_count),
                .line_count   (line_count),
                .hblank_count (hblank_count),
                .vblank_count (vblank_count),
                .pattern_sel  (pattern_sel),
                .dout         (dout_w[gi]),
                .dv_out       (dv_w[gi]),
                .hs_out       (hs_w[gi]),
                .vs_out       (vs_w[gi]),
                .frame_cnt    (frame_cnt_w[gi])
            );
        end
    endgenerate

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Model: a running frame is described by its latched sizes and the clock offset into it
    int m_act [2], m_pos [2], m_fc [2], m_pend [2];
    int m_pix [2], m_line [2], m_hbl [2], m_vbl [2], m_pat [2];
    int e_dout [2], e_dv [2], e_hs [2], e_vs [2];

    function automatic int pattern_value(input int pat, input int x, input int y, input int fc);
        case (pat)
            0:       return x % 256;
            1:       return y % 256;
            2:       return ((((x / 8) ^ (y / 8)) % 2) == 1) ? 255 : 0;
            default: return (x + y + fc) % 256;
        endcase
    endfunction

    function automatic int frame_len(input int d);
        return m_vbl[d] + m_line[d] * (m_hbl[d] + m_pix[d] * (d + 1));
    endfunction

    task automatic latch_frame(input int d);
        m_act[d]  = 1;
        m_pos[d]  = 0;
        m_pix[d]  = int'(pix_count);
        m_line[d] = int'(line_count);
        m_hbl[d]  = (hblank_count == 0) ? 1 : int'(hblank_count);
        m_vbl[d]  = (vblank_count == 0) ? 1 : int'(vblank_count);
        m_pat[d]  = int'(pattern_sel);
    endtask

    task automatic eval_pos(input int d);
        int s, u, ll, y, r, a;
        s = d + 1;
        if (m_pos[d] >= m_vbl[d]) begin
            u  = m_pos[d] - m_vbl[d];
            ll = m_hbl[d] + m_pix[d] * s;
            y  = u / ll;
            r  = u % ll;
            e_vs[d] = 1;
            if (r >= m_hbl[d]) begin
                a = r - m_hbl[d];
                e_hs[d] = 1;
                if (a % s == 0) begin
                    e_dv[d]   = 1;
                    e_dout[d] = pattern_value(m_pat[d], a / s, y, m_fc[d]);
                end
            end
        end
    endtask

    task automatic model_edge(input int d);
        logic start_ok;
        start_ok  = enable && pix_count != 0 && line_count != 0;
        e_dout[d] = 0; e_dv[d] = 0; e_hs[d] = 0; e_vs[d] = 0;
        if (rst) begin
            m_act[d] = 0; m_fc[d] = 0; m_pend[d] = 0;
        end else begin
            if (m_pend[d] != 0) begin
                m_fc[d]   = (m_fc[d] + 1) % 256;
                m_pend[d] = 0;
            end
            if (m_act[d] == 0) begin
                if (start_ok) latch_frame(d);
            end else begin
                eval_pos(d);
                if (m_pos[d] == frame_len(d) - 1) begin
                    m_pend[d] = 1;
                    if (start_ok) latch_frame(d);
                    else m_act[d] = 0;
                end else begin
                    m_pos[d]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s[S=%0d] t=%0t observed=%0h expected=%0h", tag, d + 1, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("dout",      d, 32'(dout_w[d]),      32'(e_dout[d]));
            chk("dv_out",    d, 32'(dv_w[d]),        32'(e_dv[d]));
            chk("hs_out",    d, 32'(hs_w[d]),        32'(e_hs[d]));
            chk("vs_out",    d, 32'(vs_w[d]),        32'(e_vs[d]));
            chk("frame_cnt", d, 32'(frame_cnt_w[d]), 32'(m_fc[d]));
        end
    endtask

    task automatic set_cfg(input int p, input int l, input int h, input int v, input int pat);
        pix_count    = 16'(p);
        line_count   = 16'(l);
        hblank_count = 16'(h);
        vblank_count = 16'(v);
        pattern_sel  = 2'(pat);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_pos[d] = 0; m_fc[d] = 0; m_pend[d] = 0;
            m_pix[d] = 1; m_line[d] = 1; m_hbl[d] = 1; m_vbl[d] = 1; m_pat[d] = 0;
        end
        rst = 1'b1;
        enable = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // Basic timing: 4x2, hblank 3, vblank 5, pattern x
        set_cfg(4, 2, 3, 5, 0);
        enable = 1'b1;
        repeat (60) step();
        // Sparse-friendly width of 3 pixels
        pix_count = 16'd3;
        repeat (50) step();
        enable = 1'b0;
        repeat (60) step();

        // Checkerboard 16x16 with zero blanks (treated as 1)
        set_cfg(16, 16, 0, 0, 2);
        enable = 1'b1;
        repeat (600) step();
        enable = 1'b0;
        repeat (600) step();

        // Moving pattern across several frames
        set_cfg(4, 2, 1, 2, 3);
        enable = 1'b1;
        repeat (100) step();
        enable = 1'b0;
        repeat (60) step();

        // Mid-frame parameter change and enable drop during line 1
        set_cfg(4, 2, 3, 5, 0);
        enable = 1'b1;
        repeat (15) step();
        pix_count = 16'd8;
        enable = 1'b0;
        repeat (60) step();
        enable = 1'b1;
        repeat (40) step();

        // Reset while a line is active
        set_cfg(4, 2, 3, 5, 1);
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        // Zero-size requests must never leave IDLE
        enable = 1'b0;
        repeat (60) step();
        set_cfg(0, 3, 2, 2, 0);
        enable = 1'b1;
        repeat (30) step();
        set_cfg(3, 0, 2, 2, 0);
        repeat (30) step();

        // Randomized configurations, enables and resets
        for (int i = 0; i < 40; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 9) == 0);
            step();
            rst = 1'b0;
            repeat ($urandom_range(5, 80)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 8, pixel bits; SPARSE_OUTPUT, 2, clocks per valid pixel within an active line (1 = continuous).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
REQ-003 Control ports (name, direction, width, meaning):
- enable  in  1  run frames.
- pix_count  in  16  active pixels per line.
- line_count  in  16  active lines per frame.
- hblank_count  in  16  blank clocks before each line.
- vblank_count  in  16  blank clocks between frames.
- pattern_sel  in  2  pattern select.
REQ-004 Output ports (name, direction, width, meaning):
- dout  out  WIDTH  pixel value.
- dv_out  out  1  pixel valid.
- hs_out  out  1  line-active window.
- vs_out  out  1  frame-active window.
- frame_cnt  out  8  completed-frame counter.

Function
REQ-005 All outputs SHALL be registered; dout/dv_out/hs_out/vs_out reset and power-up value 0; frame_cnt resets to 0.
REQ-006 FSM SHALL have states IDLE, VBLANK, HBLANK, ACTIVE.
REQ-007 FSM transitions:
- IDLE->VBLANK when enable=1 and pix_count!=0 and line_count!=0.
- VBLANK->HBLANK after vblank_count clocks.
- HBLANK->ACTIVE after hblank_count clocks.
- ACTIVE->HBLANK after the last pixel when lines remain.
- ACTIVE->VBLANK after the last pixel of the last line when enable=1; otherwise ACTIVE->IDLE.
REQ-008 Blank count value 0 SHALL be treated as 1.
REQ-009 pix_count, line_count, hblank_count, vblank_count and pattern_sel SHALL be latched on entry to VBLANK; changes mid-frame take effect next frame only.
REQ-010 Deasserting enable mid-frame SHALL complete the current frame, then enter IDLE; enable is sampled only in IDLE and at end of frame.
REQ-011 ACTIVE length per line SHALL be pix_count*SPARSE_OUTPUT clocks.
REQ-012 hs_out SHALL be 1 exactly during ACTIVE.
REQ-013 dv_out SHALL be 1 on the first ACTIVE clock and every SPARSE_OUTPUT clocks thereafter, giving exactly pix_count pulses per line.
REQ-014 vs_out SHALL rise on the first HBLANK clock of line 0 and fall after the last ACTIVE clock of the last line; it is 0 during VBLANK and IDLE.
REQ-015 Pixel coordinates: x = index of the dv pulse within the line (0..pix_count-1); y = line index (0..line_count-1).
REQ-016 dout SHALL be 0 whenever dv_out=0.
REQ-017 When dv_out=1, dout depends on the pattern latched per REQ-009 (truncated to WIDTH LSBs):
- 0: x
- 1: y
- 2: all-ones if x[3]^y[3], else 0
- 3: x+y+frame_cnt
REQ-018 frame_cnt SHALL increment by 1 (mod 256) on the clock vs_out falls.
REQ-019 Control-to-output latency SHALL be 1 clock: the output values for a state appear one clock after the FSM enters it; relative timing is preserved exactly.
REQ-020 Line and pixel counters SHALL wrap to 0 at their latched counts; no count SHALL exceed its latched value.

Reset
REQ-021 rst=1 on any clock, including mid-line, SHALL force IDLE, zero all counters and outputs on the next edge, and discard latched parameters.
REQ-022 After rst deasserts, the first frame SHALL start per REQ-007 with vblank preceding line 0.

Verification
REQ-023 Basic timing. Stimulus: pix=4, line=2, hbl=3, vbl=5, SPARSE_OUTPUT=1, pattern 0, enable=1. Required response:
- per frame: vs high 2*(3+4)=14 clocks, low 5.
- per line: hs high 4 clocks.
- dout sequence: 0,1,2,3 on each line.
REQ-024 Sparse output. Stimulus: SPARSE_OUTPUT=2, pix=3. Required response: hs high 6 clocks; dv pulses at hs offsets 0,2,4; dout=0 on non-dv clocks.
REQ-025 Checker and moving patterns. Stimulus: pattern 2, pix=16, line=16. Required response: dout=0xFF exactly where x[3]^y[3]=1. Stimulus: pattern 3 over 3 frames. Required response: first pixel of frame n equals n.
REQ-026 Mid-frame changes. Stimulus: change pix_count 4->8 and drop enable during line 1 of a frame. Required response: current frame completes with 4 pixels per line, then IDLE with all outputs 0; next enable gives 8-pixel lines.
REQ-027 Reset mid-line. Stimulus: rst during ACTIVE. Required response: next clock all outputs 0 and frame_cnt=0; after release, vs rises 1+vbl clocks after the IDLE exit.
REQ-028 Zero size. Stimulus: pix_count=0 or line_count=0 with enable=1. Required response: FSM stays IDLE with no dv/hs/vs activity; hblank_count=0 gives a 1-clock blank.
